mux1hot_rr_arbiter: RTL and testbench
=====================================

// Module: mux1hot_rr_arbiter
//
// PURPOSE
//  Round-robin arbiter that shares one registered output channel among N
//  valid/ready requesters. It generates the one-hot select that steers the
//  one-hot data mux, and it holds that select across multi-beat bursts
//  delimited by req_last.
//  Sits between N producer ports and a single downstream consumer. Each
//  accepted beat appears on out_* exactly 1 cycle later.
//
// PARAMETERS
//  N      4   number of requesters (>=1); also the width of every one-hot vector
//  WIDTH  8   data bits per beat
//
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        synchronous reset, active-low
//  req_valid  in   N        requester i has a beat
//  req_last   in   N        the beat from requester i ends its burst
//  req_data   in   N*WIDTH  beat data; requester i occupies [i*WIDTH +: WIDTH]
//  req_ready  out  N        one-hot (or 0) grant; a beat transfers when valid&ready
//  out_valid  out  1        output register holds a beat
//  out_ready  in   1        consumer accepts the beat
//  out_data   out  WIDTH    muxed beat
//  out_last   out  1        copy of req_last for that beat
//  out_sel    out  N        one-hot source of the beat in out_data
//  locked     out  1        a burst is in progress; the grant is pinned
//
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset is synchronous and active-low on
//    rst_n; it is sampled on the rising edge of clk.
//  - Reset values: out_valid=0, out_data=0, out_last=0, out_sel=0, locked=0.
//    The internal priority pointer ptr resets to N'b1 (requester 0 highest).
//    Reset in mid-burst drops the burst and clears the lock; no beat is
//    emitted while reset is active.
//  - load = !out_valid | out_ready. This is combinational.
//  - Candidate selection, combinational:
//    - locked=1: cand = lock_sel & req_valid.
//    - locked=0: cand = the first set bit of req_valid, searching upward from
//      the bit in ptr and wrapping from N-1 to 0.
//  - req_ready = load ? cand : 0. It is never more than one hot.
//    req_ready may depend combinationally on out_ready and req_valid.
//  - On a cycle with a grant (g = req_ready != 0):
//    - out_data  <= the req_data slice selected one-hot by g
//    - out_last  <= |(req_last & g)
//    - out_sel   <= g
//    - out_valid <= 1
//    - if |(req_last & g): locked <= 0, and ptr <= g rotated left by 1
//      (N-1 wraps to 0)
//    - otherwise: locked <= 1 and lock_sel <= g; ptr is unchanged
//  - load=1 with no grant: out_valid <= 0. out_data, out_sel and out_last
//    hold their values.
//  - load=0 (output full and stalled): all output registers hold.
//    req_ready=0.
//  - Throughput: 1 beat/cycle when out_ready=1 is held. A drain and a new
//    load happen in the same cycle with no bubble.
//  - Locked requester deasserts valid mid-burst: no other requester is granted
//    until it resumes. out_valid drops to 0 once the held beat drains.
//  - Single-beat requests (last=1 on every beat) give pure round-robin among
//    the active requesters.
//  - N=1: ptr is constant 1. The block degenerates to a 1-deep pipeline
//    register.
//  - Latency: 1 cycle, from the req handshake to out_valid.
//
// STRUCTURE
//  - Shared header mux1hot_defs.vh holds:
//    - the one-hot rotate-left macro
//    - the ONEHOT_NONE constant (all zeros)
//  - Sub-module rr_pick1hot #(N) is purely combinational.
//    - Inputs: req[N], ptr[N] (one-hot).
//    - Output: grant[N], the first set bit of req at or above ptr, wrapping.
//  - The data mux is a generic AND-OR one-hot mux over the N slices.
//    Data is selected only when out_valid will load.
//  - Sequential state: ptr, lock_sel, locked, out_valid, out_data, out_last,
//    out_sel.
//
// TESTING  (N=4, WIDTH=8 unless noted)
//  1. Reset: hold rst_n=0 for 2 clocks with all req_valid=1.
//     -> out_valid=0, out_sel=0, locked=0, req_ready=0 throughout.
//     First grant after release is req_ready=4'b0001.
//  2. Round-robin: req_valid=4'b1111, req_last=4'b1111, out_ready=1,
//     data_i=8'hA0+i.
//     -> out_data sequence A0,A1,A2,A3,A0 on consecutive cycles; out_sel
//     walks 0001,0010,0100,1000,0001.
//  3. Burst lock: req1 sends 3 beats with last on the 3rd; req0 and req2 are
//     valid throughout.
//     -> out_sel=0010 for 3 beats with locked=1 after beat 1.
//     The next grant is 0100 (ptr wrapped past 1).
//  4. Backpressure: out_ready=0 for 5 cycles with one beat 8'h5C held.
//     -> out_data stays 5C, out_valid=1, req_ready=0.
//     When out_ready=1, the next beat loads in the same cycle.
//  5. Locked stall: req2 drops valid after beat 1 of its burst for 3 cycles
//     while req0 is valid.
//     -> req0 is never granted; out_valid drops to 0. When req2 resumes,
//     beat 2 comes from req2.
//  6. Reset mid-burst: rst_n=0 while locked=1 on req3.
//     -> locked=0 and ptr=0001; after release req0 wins over req3.

Source files
------------

// File: rtl/mux1hot_rr_arbiter_pkg.sv
// Shared definitions for the one-hot round-robin arbiter: default sizes
// and the burst-lock state encoding.
package mux1hot_rr_arbiter_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_WIDTH = 8;

    // OPEN: grant follows the round-robin pointer.
    // LOCKED: grant is pinned to the requester whose burst is in flight.
    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/mux1hot_rr_arbiter_if.sv
// Bundle of the N requester channels and the single output channel.
// The arbiter uses the slave view; the surrounding producer/consumer
// environment uses the master view.
interface mux1hot_rr_arbiter_if
    import mux1hot_rr_arbiter_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH
);

    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_last;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [N-1:0]       out_sel;
    logic               locked;

    modport slave (
        input  req_valid, req_last, req_data, out_ready,
        output req_ready, out_valid, out_data, out_last, out_sel, locked
    );

    modport master (
        output req_valid, req_last, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_sel, locked
    );

endinterface

// File: rtl/mux1hot_rr_arbiter_pick.sv
// Combinational round-robin picker: returns the first set bit of req at or
// above the one-hot ptr, wrapping from N-1 back to 0.
// The request vector is doubled so the wrapped search becomes a plain
// "lowest set bit at or above ptr" search; both halves are then folded.
module rr_pick1hot
    import mux1hot_rr_arbiter_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] grant
);

    localparam logic [2*N-1:0] ONE_2N = (2*N)'(1'b1);

    logic [2*N-1:0] req2_s;
    logic [2*N-1:0] at_or_above_s;
    logic [2*N-1:0] cand2_s;
    logic [2*N-1:0] first2_s;

    assign req2_s        = {req, req};
    // ptr is one-hot, so ptr-1 marks every bit below it; invert for "at or above"
    assign at_or_above_s = ~({{N{1'b0}}, ptr} - ONE_2N);
    assign cand2_s       = req2_s & at_or_above_s;
    // isolate the lowest set bit
    assign first2_s      = cand2_s & (~cand2_s + ONE_2N);
    assign grant         = first2_s[N-1:0] | first2_s[2*N-1:N];

endmodule

// File: rtl/mux1hot_rr_arbiter.sv
// Round-robin arbiter sharing one registered output channel among N
// valid/ready requesters. The grant is one-hot, steers an AND-OR data mux,
// and stays pinned to one requester for the length of a req_last burst.
module mux1hot_rr_arbiter
    import mux1hot_rr_arbiter_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux1hot_rr_arbiter_if.slave   bus
);

    localparam logic [N-1:0] PTR_INIT = N'(1'b1);

    lock_state_e      state_r;
    lock_state_e      state_next_s;
    logic [N-1:0]     ptr_r;
    logic [N-1:0]     lock_sel_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_last_r;
    logic [N-1:0]     out_sel_r;

    logic             load_s;
    logic [N-1:0]     pick_s;
    logic [N-1:0]     cand_s;
    logic [N-1:0]     grant_s;
    logic             grant_any_s;
    logic             grant_last_s;
    logic [WIDTH-1:0] mux_data_s;

    // one-hot rotate left by one position, N-1 wraps to 0
    function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[(i + 1) % N] = v[i];
        end
        return r;
    endfunction

    // output stage can take a new beat when empty or draining this cycle
    assign load_s = ~out_valid_r | bus.out_ready;

    rr_pick1hot #(.N(N)) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr_r),
        .grant (pick_s)
    );

    // candidate: pinned requester during a burst, round-robin pick otherwise
    always_comb begin
        cand_s = '0;
        if (state_r == ST_LOCKED) begin
            cand_s = lock_sel_r & bus.req_valid;
        end else begin
            cand_s = pick_s;
        end
    end

    // grant only when the output can load and not while reset is applied
    always_comb begin
        grant_s = '0;
        if (rst_n && load_s) begin
            grant_s = cand_s;
        end else begin
            grant_s = '0;
        end
    end

    assign grant_any_s  = |grant_s;
    assign grant_last_s = |(bus.req_last & grant_s);

    // AND-OR one-hot data mux; zero whenever nothing is granted
    always_comb begin
        mux_data_s = '0;
        for (int i = 0; i < N; i++) begin
            mux_data_s = mux_data_s | (bus.req_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
        end
    end

    // burst lock next-state: lock on a non-last beat, release on the last beat
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_OPEN: begin
                if (grant_any_s && !grant_last_s) begin
                    state_next_s = ST_LOCKED;
                end else begin
                    state_next_s = ST_OPEN;
                end
            end
            ST_LOCKED: begin
                if (grant_any_s && grant_last_s) begin
                    state_next_s = ST_OPEN;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: state_next_s = ST_OPEN;
        endcase
    end

    // burst lock state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_OPEN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // priority pointer, lock owner and the registered output channel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r       <= PTR_INIT;
            lock_sel_r  <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_sel_r   <= '0;
        end else if (grant_any_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= mux_data_s;
            out_last_r  <= grant_last_s;
            out_sel_r   <= grant_s;
            if (grant_last_s) begin
                ptr_r <= rotl1(grant_s);
            end else begin
                lock_sel_r <= grant_s;
            end
        end else if (load_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_sel   = out_sel_r;
    assign bus.locked    = (state_r == ST_LOCKED);

endmodule

// File: tb/tb_mux1hot_rr_arbiter.sv
// Self-checking bench for mux1hot_rr_arbiter (N=4, WIDTH=8): directed
// scenarios followed by randomized traffic against an index-based model.
module tb_mux1hot_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    mux1hot_rr_arbiter_if #(.N(4), .WIDTH(8)) bus ();

    mux1hot_rr_arbiter #(.N(4), .WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: priority index, burst owner index (-1 = none), output stage
    int         m_ptr = 0;
    int         m_owner = -1;
    bit         m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         m_last = 1'b0;
    logic [3:0] m_sel = 4'b0000;
    logic [3:0] exp_r;
    logic [7:0] exp_d;

    function automatic logic [3:0] model_ready();
        if (!rst_n) return 4'b0000;
        if (m_valid && !bus.out_ready) return 4'b0000;
        if (m_owner >= 0) return bus.req_valid[m_owner] ? 4'(1 << m_owner) : 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (bus.req_valid[(m_ptr + k) % 4]) return 4'(1 << ((m_ptr + k) % 4));
        end
        return 4'b0000;
    endfunction

    task automatic tick();
        logic [3:0] r;
        bit ld;
        int g;
        r  = model_ready();
        ld = !m_valid || bus.out_ready;
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0; m_owner = -1; m_valid = 1'b0; m_data = 8'h00; m_last = 1'b0; m_sel = 4'b0000;
        end else if (r != 4'b0000) begin
            g = 0;
            for (int i = 0; i < 4; i++) if (r[i]) g = i;
            m_data  = bus.req_data[g*8 +: 8];
            m_last  = bus.req_last[g];
            m_sel   = r;
            m_valid = 1'b1;
            if (m_last) begin
                m_owner = -1;
                m_ptr   = (g + 1) % 4;
            end else begin
                m_owner = g;
            end
        end else if (ld) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 4'b1111; bus.req_last = 4'b1111;
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (bus.req_ready !== 4'b0000) begin
                failures++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out_sel !== 4'b0000 || bus.locked !== 1'b0) begin
                failures++;
                $display("FAIL reset_state got valid=%b sel=%b locked=%b exp 0/0000/0", bus.out_valid, bus.out_sel, bus.locked);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++; $display("FAIL reset_first_grant got=%b exp=0001", bus.req_ready);
        end
        bus.req_valid = 4'b0000;
        #1;
        tick();
    endtask

    task automatic test_round_robin();
        bus.req_valid = 4'b1111; bus.req_last = 4'b1111;
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_r = 4'(1 << (k % 4));
            checks++;
            if (bus.req_ready !== exp_r) begin
                failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, bus.req_ready, exp_r);
            end
            tick();
            exp_d = 8'hA0 + 8'(k % 4);
            checks++;
            if (bus.out_data !== exp_d || bus.out_sel !== exp_r || bus.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL rr_out[%0d] got data=%h sel=%b valid=%b exp %h/%b/1", k, bus.out_data, bus.out_sel, bus.out_valid, exp_d, exp_r);
            end
        end
    endtask

    task automatic test_burst_lock();
        bus.req_valid = 4'b0111; bus.out_ready = 1'b1;
        bus.req_data = {8'hE3, 8'hE2, 8'hB0, 8'hE0};
        for (int b = 0; b < 3; b++) begin
            bus.req_data[15:8] = 8'hB0 + 8'(b);
            bus.req_last = (b == 2) ? 4'b0111 : 4'b0101;
            #1;
            checks++;
            if (bus.req_ready !== 4'b0010) begin
                failures++; $display("FAIL burst_ready[%0d] got=%b exp=0010", b, bus.req_ready);
            end
            tick();
            exp_d = 8'hB0 + 8'(b);
            checks++;
            if (bus.out_sel !== 4'b0010 || bus.out_data !== exp_d || bus.locked !== (b < 2)) begin
                failures++;
                $display("FAIL burst_out[%0d] got sel=%b data=%h locked=%b exp 0010/%h/%0d", b, bus.out_sel, bus.out_data, bus.locked, exp_d, (b < 2));
            end
        end
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            failures++; $display("FAIL burst_next got=%b exp=0100", bus.req_ready);
        end
        tick();
        checks++;
        if (bus.out_sel !== 4'b0100 || bus.out_data !== 8'hE2) begin
            failures++; $display("FAIL burst_next_out got sel=%b data=%h exp 0100/e2", bus.out_sel, bus.out_data);
        end
    endtask

    task automatic test_backpressure();
        bus.req_valid = 4'b0001; bus.req_last = 4'b1111; bus.out_ready = 1'b1;
        bus.req_data[7:0] = 8'h5C;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++; $display("FAIL bp_load got=%b exp=0001", bus.req_ready);
        end
        tick();
        bus.req_data[7:0] = 8'h11;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (bus.req_ready !== 4'b0000) begin
                failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, bus.req_ready);
            end
            tick();
            checks++;
            if (bus.out_data !== 8'h5C || bus.out_valid !== 1'b1) begin
                failures++; $display("FAIL bp_hold[%0d] got data=%h valid=%b exp 5c/1", k, bus.out_data, bus.out_valid);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++; $display("FAIL bp_release got=%b exp=0001", bus.req_ready);
        end
        tick();
        checks++;
        if (bus.out_data !== 8'h11 || bus.out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_next got data=%h valid=%b exp 11/1", bus.out_data, bus.out_valid);
        end
    endtask

    task automatic test_locked_stall();
        bus.req_valid = 4'b0101; bus.req_last = 4'b0001; bus.out_ready = 1'b1;
        bus.req_data[23:16] = 8'hC0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            failures++; $display("FAIL stall_first got=%b exp=0100", bus.req_ready);
        end
        tick();
        checks++;
        if (bus.locked !== 1'b1 || bus.out_data !== 8'hC0) begin
            failures++; $display("FAIL stall_beat1 got locked=%b data=%h exp 1/c0", bus.locked, bus.out_data);
        end
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.req_ready !== 4'b0000) begin
                failures++; $display("FAIL stall_ready[%0d] got=%b exp=0000", k, bus.req_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.locked !== 1'b1) begin
                failures++; $display("FAIL stall_out[%0d] got valid=%b locked=%b exp 0/1", k, bus.out_valid, bus.locked);
            end
        end
        bus.req_valid = 4'b0101; bus.req_last = 4'b0101;
        bus.req_data[23:16] = 8'hC1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            failures++; $display("FAIL stall_resume got=%b exp=0100", bus.req_ready);
        end
        tick();
        checks++;
        if (bus.out_data !== 8'hC1 || bus.out_sel !== 4'b0100 || bus.locked !== 1'b0) begin
            failures++; $display("FAIL stall_beat2 got data=%h sel=%b locked=%b exp c1/0100/0", bus.out_data, bus.out_sel, bus.locked);
        end
    endtask

    task automatic test_reset_mid_burst();
        bus.req_valid = 4'b1001; bus.req_last = 4'b0000; bus.out_ready = 1'b1;
        bus.req_data = {8'hD0, 8'h00, 8'h00, 8'hD7};
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            failures++; $display("FAIL rmb_grant got=%b exp=1000", bus.req_ready);
        end
        tick();
        checks++;
        if (bus.locked !== 1'b1) begin
            failures++; $display("FAIL rmb_locked got=%b exp=1", bus.locked);
        end
        rst_n = 1'b0;
        #1;
        tick();
        checks++;
        if (bus.locked !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL rmb_reset got locked=%b valid=%b exp 0/0", bus.locked, bus.out_valid);
        end
        rst_n = 1'b1; bus.req_last = 4'b1111;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++; $display("FAIL rmb_after got=%b exp=0001", bus.req_ready);
        end
        tick();
        checks++;
        if (bus.out_sel !== 4'b0001 || bus.out_data !== 8'hD7) begin
            failures++; $display("FAIL rmb_after_out got sel=%b data=%h exp 0001/d7", bus.out_sel, bus.out_data);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            bus.req_valid = 4'($urandom);
            bus.req_last  = 4'($urandom);
            bus.req_data  = $urandom;
            bus.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            exp_r = model_ready();
            checks++;
            if (bus.req_ready !== exp_r) begin
                failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, bus.req_ready, exp_r);
            end
            tick();
            checks++;
            if (bus.out_valid !== m_valid || bus.out_data !== m_data || bus.out_last !== m_last ||
                bus.out_sel !== m_sel || bus.locked !== (m_owner >= 0)) begin
                failures++;
                $display("FAIL rand_out[%0d] got v=%b d=%h l=%b s=%b lk=%b exp v=%b d=%h l=%b s=%b lk=%0d",
                         c, bus.out_valid, bus.out_data, bus.out_last, bus.out_sel, bus.locked,
                         m_valid, m_data, m_last, m_sel, (m_owner >= 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_backpressure();
        test_locked_stall();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
